// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 2^INDEXBITS lines of four words,
// refilled word by word from main memory while the core is stalled.
module icache #(
    parameter int INDEXBITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instrack,
    input  logic        flush,
    output logic        memreq,
    output logic [31:0] memadr,
    input  logic [31:0] memrdata,
    input  logic        memack
);

    localparam int LINES   = 1 << INDEXBITS;
    localparam int TAGBITS = 28 - INDEXBITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                 state;
    logic [3:0][31:0]       data [LINES];
    logic [TAGBITS-1:0]     tags [LINES];
    logic [LINES-1:0]       valid;
    logic [TAGBITS-1:0]     filltag;
    logic [INDEXBITS-1:0]   fillindex;
    logic [1:0]             counter;
    logic                   kill;

    logic [1:0]             offset;
    logic [INDEXBITS-1:0]   index;
    logic [TAGBITS-1:0]     tag;
    logic                   unusedbits;

    assign offset     = pc[3:2];
    assign index      = pc[4+INDEXBITS-1:4];
    assign tag        = pc[31:4+INDEXBITS];
    assign unusedbits = ^pc[1:0];

    // Lookup is combinational so a hit returns the word in the same cycle as the pc.
    assign instr    = data[index][offset];
    assign instrack = (state == IDLE) && valid[index] && (tags[index] == tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= '0;
            memreq    <= 1'b0;
            memadr    <= '0;
            counter   <= 2'd0;
            kill      <= 1'b0;
            filltag   <= '0;
            fillindex <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (!instrack) begin
                        filltag   <= tag;
                        fillindex <= index;
                        counter   <= 2'd0;
                        kill      <= 1'b0;
                        memreq    <= 1'b1;
                        memadr    <= {tag, index, 4'b0000};
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // A flush during a fill marks the in-flight line as dead on arrival.
                    if (flush) begin
                        valid <= '0;
                        kill  <= 1'b1;
                    end
                    if (memack) begin
                        counter <= counter + 2'd1;
                        memadr  <= {filltag, fillindex, counter + 2'd1, 2'b00};
                        if (counter == 2'd3) begin
                            if (!flush && !kill) begin
                                valid[fillindex] <= 1'b1;
                            end
                            kill   <= 1'b0;
                            memreq <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage carries no reset; the valid bits alone decide whether it is usable.
    always_ff @(posedge clk) begin
        if (state == FILL && memack) begin
            data[fillindex][counter] <= memrdata;
            if (counter == 2'd3) begin
                tags[fillindex] <= filltag;
            end
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache against a memory that answers memadr^0xA5A50000,
// acking every cycle or every third cycle of a fill.
module tb_icache;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instrack;
    logic        flush;
    logic        memreq;
    logic [31:0] memadr;
    logic [31:0] memrdata;
    logic        memack;

    int checks;
    int failures;
    int ackPeriod;
    int phase;

    icache #(.INDEXBITS(4)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .instr(instr),
        .instrack(instrack),
        .flush(flush),
        .memreq(memreq),
        .memadr(memadr),
        .memrdata(memrdata),
        .memack(memack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: counts request cycles and acks on every ackPeriod-th one.
    initial begin
        memack   = 1'b0;
        memrdata = '0;
        phase    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (memreq) phase = phase + 1;
            else phase = 0;
            memack   = memreq && ((phase % ackPeriod) == 0);
            memrdata = memadr ^ 32'hA5A50000;
        end
    end

    // Cycle 0 is the current negedge: pc misses, four fill cycles, hit in cycle 5.
    task automatic runFill(input logic [31:0] base);
        logic [31:0] expAdr;
        pc = base;
        #1;
        checks++;
        if (instrack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL miss_%h: instrack got %b expected 0", base, instrack);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            expAdr = base + 32'(4 * k);
            checks++;
            if (memreq !== 1'b1 || memadr !== expAdr || instrack !== 1'b0) begin
                failures++;
                $display("[TB] FAIL fill_%h_w%0d: memreq=%b memadr=%h instrack=%b expected 1 %h 0",
                         base, k, memreq, memadr, instrack, expAdr);
            end
        end
        @(negedge clk);
        checks++;
        if (instrack !== 1'b1 || memreq !== 1'b0 || instr !== (base ^ 32'hA5A50000)) begin
            failures++;
            $display("[TB] FAIL hit_%h: instrack=%b memreq=%b instr=%h expected 1 0 %h",
                     base, instrack, memreq, instr, base ^ 32'hA5A50000);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        pc        = 32'h00000040;
        ackPeriod = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (instrack !== 1'b0 || memreq !== 1'b0 || memadr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state: instrack=%b memreq=%b memadr=%h expected 0 0 00000000",
                     instrack, memreq, memadr);
        end
    endtask

    task automatic test_miss_fill();
        reset = 1'b0;
        runFill(32'h00000040);
    endtask

    task automatic test_hit();
        pc = 32'h0000004C;
        #1;
        checks++;
        if (instrack !== 1'b1 || instr !== 32'hA5A5004C || memreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hit_same_line: instrack=%b instr=%h memreq=%b expected 1 a5a5004c 0",
                     instrack, instr, memreq);
        end
        @(negedge clk);
        checks++;
        if (instrack !== 1'b1 || memreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hit_stays: instrack=%b memreq=%b expected 1 0", instrack, memreq);
        end
    endtask

    task automatic test_conflict();
        runFill(32'h00000140);
        @(negedge clk);
        runFill(32'h00000040);
        pc = 32'h00000048;
        #1;
        checks++;
        if (instrack !== 1'b1 || instr !== 32'hA5A50048) begin
            failures++;
            $display("[TB] FAIL conflict_refill_hit: instrack=%b instr=%h expected 1 a5a50048",
                     instrack, instr);
        end
    endtask

    task automatic test_slow_memory();
        logic [31:0] expAdr;
        @(negedge clk);
        ackPeriod = 3;
        pc = 32'h00000080;
        #1;
        checks++;
        if (instrack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL slow_miss: instrack got %b expected 0", instrack);
        end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            expAdr = 32'h00000080 + 32'(4 * ((cyc - 1) / 3));
            checks++;
            if (memreq !== 1'b1 || memadr !== expAdr || instrack !== 1'b0) begin
                failures++;
                $display("[TB] FAIL slow_cycle%0d: memreq=%b memadr=%h instrack=%b expected 1 %h 0",
                         cyc, memreq, memadr, instrack, expAdr);
            end
        end
        @(negedge clk);
        checks++;
        if (instrack !== 1'b1 || instr !== 32'hA5A50080 || memreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL slow_hit: instrack=%b instr=%h memreq=%b expected 1 a5a50080 0",
                     instrack, instr, memreq);
        end
        ackPeriod = 1;
    endtask

    task automatic test_flush_idle();
        pc = 32'h00000040;
        #1;
        checks++;
        if (instrack !== 1'b1) begin
            failures++;
            $display("[TB] FAIL preflush_hit40: instrack got %b expected 1", instrack);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (instrack !== 1'b0 || memreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle: instrack=%b memreq=%b expected 0 0", instrack, memreq);
        end
        runFill(32'h00000040);
        @(negedge clk);
        runFill(32'h00000080);
    endtask

    task automatic test_flush_fill();
        @(negedge clk);
        runFill(32'h00000140);
        @(negedge clk);
        pc = 32'h00000040;
        @(negedge clk);
        checks++;
        if (memreq !== 1'b1 || memadr !== 32'h00000040) begin
            failures++;
            $display("[TB] FAIL kill_start: memreq=%b memadr=%h expected 1 00000040", memreq, memadr);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (memreq !== 1'b1 || memadr !== 32'h00000048) begin
            failures++;
            $display("[TB] FAIL kill_continues: memreq=%b memadr=%h expected 1 00000048", memreq, memadr);
        end
        @(negedge clk);
        checks++;
        if (memadr !== 32'h0000004C) begin
            failures++;
            $display("[TB] FAIL kill_last_word: memadr=%h expected 0000004c", memadr);
        end
        @(negedge clk);
        checks++;
        if (instrack !== 1'b0 || memreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL kill_invalid: instrack=%b memreq=%b expected 0 0", instrack, memreq);
        end
        runFill(32'h00000040);
        // 0x80 was wiped by the same mid-fill flush; flush again on its final ack.
        @(negedge clk);
        pc = 32'h00000080;
        #1;
        checks++;
        if (instrack !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flushed80_miss: instrack got %b expected 0", instrack);
        end
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (instrack !== 1'b0 || memreq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_last_ack: instrack=%b memreq=%b expected 0 0", instrack, memreq);
        end
        runFill(32'h00000080);
    endtask

    task automatic test_reset_mid_fill();
        @(negedge clk);
        pc = 32'h00000040;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (memreq !== 1'b0 || instrack !== 1'b0 || memadr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_reset: memreq=%b instrack=%b memadr=%h expected 0 0 00000000",
                     memreq, instrack, memadr);
        end
        @(negedge clk);
        reset = 1'b0;
        runFill(32'h00000040);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_miss_fill();
        test_hit();
        test_conflict();
        test_slow_memory();
        test_flush_idle();
        test_flush_fill();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
